// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner. It adds an anti-ghost blank interval
// at the start of each digit slot and uses the low counter bits for brightness PWM.
module seg7_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  digit_en_i,
  input  logic [3:0]  bright_i,
  output logic [7:0]  seg_o,
  output logic [3:0]  anodes_o,
  output logic [1:0]  digit_idx_o,
  output logic        frame_o
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] dig_q, dig_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  en_q, en_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic [1:0]  idxo_q, idxo_d;
  logic        frame_q, frame_d;
  logic        latch;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;  4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;  4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;  4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;  4'hE: dec7 = 7'h06;  default: dec7 = 7'h0E;
    endcase
  endfunction

  // Segment/anode outputs are registered from the current state and counter, so
  // they trail the counter by one cycle; digit_idx_o is delayed the same way.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    dp_d    = dp_q;
    en_d    = en_q;
    seg_d   = 8'hFF;
    an_d    = 4'hF;
    idxo_d  = idx_q;
    latch   = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
      idxo_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = 2'd0;
          idxo_d  = 2'd0;
          latch   = 1'b1;
        end
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BLANK - 1)) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          seg_d = {~dp_q[idx_q], dec7(dig_q[{idx_q, 2'b00} +: 4])};
          if (en_q[idx_q] && (cnt_q[3:0] <= bright_i)) an_d[idx_q] = 1'b0;
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = S_BLANK;
            latch   = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (latch) begin
      dig_d = digits_i;
      dp_d  = dp_i;
      en_d  = digit_en_i;
    end
    frame_d = latch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      dig_q   <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      seg_q   <= 8'hFF;
      an_q    <= 4'hF;
      idxo_q  <= 2'd0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      idxo_q  <= idxo_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o       = seg_q;
  assign anodes_o    = an_q;
  assign digit_idx_o = idxo_q;
  assign frame_o     = frame_q;

endmodule
